scan_sched: RTL and testbench



---
 rtl/scan_pkg.sv | 24 ++
 rtl/scan_sched_if.sv | 48 ++++
 rtl/scan_pos_cnt.sv | 57 +++++
 rtl/scan_sched.sv | 138 +++++++++++++
 tb/tb_scan_sched.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Brief    : Shared state encodings and default geometry for the raster-scan
//            scheduler.
// Revision : 1.0
// ============================================================================
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int c_COLS_DEF   = 640;
  localparam int c_ROWS_DEF   = 480;
  localparam int c_RADIUS_DEF = 3;
  localparam int c_CW_DEF     = $clog2(c_COLS_DEF);
  localparam int c_RW_DEF     = $clog2(c_ROWS_DEF);
  localparam int c_BANK_W     = 3;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_sched_if
// Brief    : Pixel-input handshake, line-buffer write and window-centre bus of
//            the scheduler. drop_cnt exists only with SCAN_DROP_CNT_EN.
// Revision : 1.0
// ============================================================================
interface scan_sched_if
  import scan_pkg::*;
#(
  parameter int CW = c_CW_DEF,
  parameter int RW = c_RW_DEF
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic                busy;
  logic                lb_wr_en;
  logic [c_BANK_W-1:0] lb_bank;
  logic [CW-1:0]       lb_wr_addr;
  logic                win_valid;
  logic [CW-1:0]       ctr_col;
  logic [RW-1:0]       ctr_row;
  logic                frame_done;
`ifdef SCAN_DROP_CNT_EN
  logic [15:0]         drop_cnt;
`endif

  modport master (
`ifdef SCAN_DROP_CNT_EN
    input  drop_cnt,
`endif
    output start, in_valid,
    input  in_ready, busy, lb_wr_en, lb_bank, lb_wr_addr,
    input  win_valid, ctr_col, ctr_row, frame_done
  );

  modport slave (
`ifdef SCAN_DROP_CNT_EN
    output drop_cnt,
`endif
    input  start, in_valid,
    output in_ready, busy, lb_wr_en, lb_bank, lb_wr_addr,
    output win_valid, ctr_col, ctr_row, frame_done
  );

endinterface : scan_sched_if
`default_nettype wire

// File: rtl/scan_pos_cnt.sv
`default_nettype none
// ============================================================================
// Module   : scan_pos_cnt
// Brief    : Column/row position counters and line-buffer ring bank pointer.
// Revision : 1.0
// ============================================================================
module scan_pos_cnt
  import scan_pkg::*;
#(
  parameter int COLS   = c_COLS_DEF,
  parameter int ROWS   = c_ROWS_DEF,
  parameter int RADIUS = c_RADIUS_DEF,
  parameter int CW     = c_CW_DEF,
  parameter int RW     = c_RW_DEF
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                i_clr,
  input  wire logic                i_inc,
  output logic      [CW-1:0]       o_col,
  output logic      [RW-1:0]       o_row,
  output logic      [c_BANK_W-1:0] o_bank,
  output logic                     o_last
);

  localparam logic [CW-1:0]       c_COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]       c_ROW_LAST  = RW'(ROWS - 1);
  localparam logic [c_BANK_W-1:0] c_BANK_LAST = c_BANK_W'(2 * RADIUS);

  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [c_BANK_W-1:0] r_bank;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_bank <= '0;
    end else if (i_inc) begin
      if (r_col == c_COL_LAST) begin
        r_col  <= '0;
        r_row  <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
        // The ring holds 2R+1 lines; each new row overwrites the oldest bank.
        r_bank <= (r_bank == c_BANK_LAST) ? '0 : r_bank + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_bank = r_bank;
  assign o_last = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

endmodule : scan_pos_cnt
`default_nettype wire

// File: rtl/scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : scan_sched
// Brief    : Raster-scan scheduler: frame FSM, line-buffer write control and
//            blur window-valid generation. Optional macro SCAN_DROP_CNT_EN
//            adds a saturating count of pixels offered outside RUN.
// Revision : 1.0
// ============================================================================
module scan_sched
  import scan_pkg::*;
#(
  parameter int COLS   = c_COLS_DEF,
  parameter int ROWS   = c_ROWS_DEF,
  parameter int RADIUS = c_RADIUS_DEF,
  parameter int CW     = c_CW_DEF,
  parameter int RW     = c_RW_DEF
) (
  input wire logic   clk,
  input wire logic   rst_n,
  scan_sched_if.slave bus
);

  state_t              r_state;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_win_valid;
  logic [CW-1:0]       r_ctr_col;
  logic [RW-1:0]       r_ctr_row;

  logic                w_accept;
  logic                w_clr;
  logic                w_last;
  logic                w_win;
  logic [CW-1:0]       w_col;
  logic [RW-1:0]       w_row;
  logic [c_BANK_W-1:0] w_bank;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_clr    = (r_state == IDLE) & bus.start;

  scan_pos_cnt #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .RADIUS (RADIUS),
    .CW     (CW),
    .RW     (RW)
  ) u_pos (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_accept),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_bank (w_bank),
    .o_last (w_last)
  );

  // Only pixels at least 2R into both axes complete a window; no border padding.
  assign w_win = w_accept && (w_row >= RW'(2 * RADIUS)) && (w_col >= CW'(2 * RADIUS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= RUN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          if (w_accept && w_last) begin
            r_state      <= DONE;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_in_ready   <= 1'b0;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_ctr_col   <= '0;
      r_ctr_row   <= '0;
    end else begin
      r_win_valid <= w_win;
      if (w_win) begin
        r_ctr_col <= w_col - CW'(RADIUS);
        r_ctr_row <= w_row - RW'(RADIUS);
      end
    end
  end

`ifdef SCAN_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (bus.in_valid && (r_state != RUN) && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif

  assign bus.in_ready   = r_in_ready;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.lb_wr_en   = w_accept;
  assign bus.lb_wr_addr = w_col;
  assign bus.lb_bank    = w_bank;
  assign bus.win_valid  = r_win_valid;
  assign bus.ctr_col    = r_ctr_col;
  assign bus.ctr_row    = r_ctr_row;

endmodule : scan_sched
`default_nettype wire

// File: tb/tb_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_sched
// Brief    : Scoreboard bench for scan_sched on an 8x6 frame with radius 1.
// Revision : 1.0
// ============================================================================
module tb_scan_sched;

  localparam int COLS   = 8;
  localparam int ROWS   = 6;
  localparam int RADIUS = 1;
  localparam int CW     = 4;
  localparam int RW     = 3;
  localparam int NPIX   = COLS * ROWS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_sched_if #(.CW(CW), .RW(RW)) bus ();

  scan_sched #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .RADIUS (RADIUS),
    .CW     (CW),
    .RW     (RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] lb_q[$];
  logic [31:0] win_q[$];
  int          done_q[$];
  bit          stim_acc      = 1'b0;
  bit          prev_stim_acc = 1'b0;
  int          acc_seen      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whether the bench offered an acceptable pixel in the cycle just ended
  always @(posedge clk) prev_stim_acc <= stim_acc;

  // Monitor: pops expectations whenever the DUT presents an output event
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) acc_seen = 0;
    if (bus.lb_wr_en === 1'b1) begin
      acc_seen++;
      if (lb_q.size() == 0) check("lb_unexpected", 1, 0);
      else begin
        e = lb_q.pop_front();
        check("lb_addr_bank", 32'({bus.lb_wr_addr, bus.lb_bank}), e);
      end
    end
    if (bus.win_valid === 1'b1) begin
      check("win_in_gap", 32'(prev_stim_acc), 1);
      if (win_q.size() == 0) check("win_unexpected", 1, 0);
      else begin
        e = win_q.pop_front();
        check("win_ctr", 32'({bus.ctr_col, bus.ctr_row}), e);
      end
    end
    if (bus.frame_done === 1'b1) begin
      check("done_after_last", 32'(prev_stim_acc), 1);
      check("done_accepts", acc_seen, NPIX);
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else void'(done_q.pop_front());
      acc_seen = 0;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    repeat (4) cycle();
    check({tag, "_lb_left"},   lb_q.size(),   0);
    check({tag, "_win_left"},  win_q.size(),  0);
    check({tag, "_done_left"}, done_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy),       0);
    check({tag, "_ready"}, 32'(bus.in_ready),   0);
    check({tag, "_win"},   32'(bus.win_valid),  0);
    check({tag, "_done"},  32'(bus.frame_done), 0);
    check({tag, "_wren"},  32'(bus.lb_wr_en),   0);
    check({tag, "_bank"},  32'(bus.lb_bank),    0);
    check({tag, "_ctr"},   32'({bus.ctr_col, bus.ctr_row}), 0);
  endtask

  // gap: alternate in_valid 1,0; mid_start: pixel index to pulse start with;
  // abort_at: stop offering pixels at this index; extra: in_valid during DONE
  task automatic run_frame(input bit gap, input int mid_start, input int abort_at, input bit extra);
    int k;
    int col;
    int row;
    bit ph;
    k  = 0;
    ph = 1'b0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    while (k < NPIX && k != abort_at) begin
      if (!gap || !ph) begin
        col = k % COLS;
        row = k / COLS;
        bus.in_valid = 1'b1;
        stim_acc     = 1'b1;
        bus.start    = (k == mid_start);
        lb_q.push_back(32'({CW'(col), 3'(row % (2 * RADIUS + 1))}));
        if (row >= 2 * RADIUS && col >= 2 * RADIUS)
          win_q.push_back(32'({CW'(col - RADIUS), RW'(row - RADIUS)}));
        if (k == NPIX - 1) done_q.push_back(1);
        k++;
      end else begin
        bus.in_valid = 1'b0;
        stim_acc     = 1'b0;
        bus.start    = 1'b0;
      end
      if (gap) ph = ~ph;
      cycle();
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    stim_acc     = 1'b0;
    if (k == NPIX) begin
      check("busy_in_done",  32'(bus.busy),     1);
      check("ready_in_done", 32'(bus.in_ready), 0);
      bus.in_valid = extra;
      cycle();
      bus.in_valid = 1'b0;
      check("busy_after_done", 32'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    repeat (2) cycle();
    check_all_zero("reset");

    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    repeat (5) begin
      cycle();
      check("idle_ready", 32'(bus.in_ready), 0);
      check("idle_wren",  32'(bus.lb_wr_en), 0);
    end
    bus.in_valid = 1'b0;
    cycle();

    run_frame(1'b0, -1, -1, 1'b0);
    check_empty("full");

    run_frame(1'b1, -1, -1, 1'b0);
    check_empty("stall");

    run_frame(1'b0, -1, 20, 1'b0);
    rst_n = 1'b0;
    cycle();
    check_all_zero("abort");
    cycle();
    rst_n = 1'b1;
    check_empty("abort");

    run_frame(1'b0, 10, -1, 1'b0);
    check_empty("restart");

`ifdef SCAN_DROP_CNT_EN
    rst_n = 1'b0;
    cycle();
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    repeat (5) cycle();
    bus.in_valid = 1'b0;
    cycle();
    run_frame(1'b0, -1, -1, 1'b1);
    check_empty("drop1");
    run_frame(1'b0, -1, -1, 1'b1);
    check_empty("drop2");
    check("drop_cnt", 32'(bus.drop_cnt), 7);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    check("drop_cnt_after_start", 32'(bus.drop_cnt), 7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_scan_sched
`default_nettype wire
